// File: rtl/psk_demod.sv
// Coherent BPSK/QPSK symbol demodulator.
// The received I/Q samples are mixed with the recovered carrier, and the
// products are integrated over each symbol. A hard constellation decision is
// made at each symbol dump. Decided symbols leave on an AXI-Stream master
// through a two-entry output buffer whose outputs are all registered.
module psk_demod #(
  parameter int WIDTH = 12,
  parameter int BYTES = 1
) (
  input  logic                    clk_16M384,
  input  logic                    rst_16M384,
  input  logic signed [WIDTH-1:0] rx_I,
  input  logic signed [WIDTH-1:0] rx_Q,
  input  logic                    rx_vld,
  input  logic                    rx_last,
  input  logic                    rx_is_bpsk,
  input  logic signed [WIDTH-1:0] carrier_I,
  input  logic signed [WIDTH-1:0] carrier_Q,
  input  logic [3:0]              DUMP_CNT,
  output logic [BYTES*8-1:0]      m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    m_tuser,
  output logic                    overflow,
  output logic                    sym_clk_1M024
);

  localparam int PW = 2 * WIDTH;   // product width
  localparam int DW = PW + 1;      // mixed-term width
  localparam int AW = PW + 5;      // accumulator width
  localparam int OW = BYTES * 8;   // stream data width

  logic [3:0]           cnt;
  logic signed [PW-1:0] p0, p1, p2, p3;
  logic                 dump1, vld1, last1, bpsk1;
  logic signed [AW-1:0] acc_d, acc_e, sym_d, sym_e;
  logic                 sym_push, sym_last, sym_bpsk;
  logic                 dec_push, dec_last, dec_bpsk;
  logic [1:0]           dec_bits;
  logic                 out_valid, out_last, out_user;
  logic [1:0]           out_bits;
  logic                 buf_valid, buf_last, buf_user;
  logic [1:0]           buf_bits;
  logic                 ovf;
  logic                 pop;
  logic signed [DW-1:0] d_term, e_term;
  logic signed [AW-1:0] acc_d_next, acc_e_next;

  // Sign-extend a sample to product width so the multiply keeps full precision.
  function automatic logic signed [PW-1:0] sext_w(input logic signed [WIDTH-1:0] x);
    return {{WIDTH{x[WIDTH-1]}}, x};
  endfunction

  // Hard decision: QPSK picks the dominant axis, BPSK only looks at the I sign.
  function automatic logic [1:0] decide(input logic signed [AW-1:0] sd,
                                        input logic signed [AW-1:0] se,
                                        input logic bpsk);
    logic [AW-1:0] ad;
    logic [AW-1:0] ae;
    ad = sd[AW-1] ? -sd : sd;
    ae = se[AW-1] ? -se : se;
    if (bpsk) begin
      decide = {sd[AW-1], 1'b0};
    end else if (ad >= ae) begin
      decide = sd[AW-1] ? 2'b11 : 2'b00;
    end else begin
      decide = (!se[AW-1] && (se != {AW{1'b0}})) ? 2'b10 : 2'b01;
    end
  endfunction

  // Free-running symbol phase counter.
  always_ff @(posedge clk_16M384) begin
    if (!rst_16M384) begin
      cnt <= 4'd0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

  // Stage 1: register the four mixer products and the per-sample flags.
  always_ff @(posedge clk_16M384) begin
    if (!rst_16M384) begin
      p0    <= {PW{1'b0}};
      p1    <= {PW{1'b0}};
      p2    <= {PW{1'b0}};
      p3    <= {PW{1'b0}};
      dump1 <= 1'b0;
      vld1  <= 1'b0;
      last1 <= 1'b0;
      bpsk1 <= 1'b0;
    end else begin
      if (rx_vld) begin
        p0 <= sext_w(rx_I) * sext_w(carrier_I);
        p1 <= sext_w(rx_Q) * sext_w(carrier_Q);
        p2 <= sext_w(rx_I) * sext_w(carrier_Q);
        p3 <= sext_w(rx_Q) * sext_w(carrier_I);
      end else begin
        p0 <= {PW{1'b0}};
        p1 <= {PW{1'b0}};
        p2 <= {PW{1'b0}};
        p3 <= {PW{1'b0}};
      end
      dump1 <= (cnt == DUMP_CNT);
      vld1  <= rx_vld;
      last1 <= rx_last;
      bpsk1 <= rx_is_bpsk;
    end
  end

  // Combine products into the in-phase (D) and quadrature (E) terms and form the running sums.
  always_comb begin
    d_term     = {p0[PW-1], p0} + {p1[PW-1], p1};
    e_term     = {p2[PW-1], p2} - {p3[PW-1], p3};
    acc_d_next = acc_d + {{(AW-DW){d_term[DW-1]}}, d_term};
    acc_e_next = acc_e + {{(AW-DW){e_term[DW-1]}}, e_term};
  end

  // Stage 2: integrate and dump; the dump sample's term lands in the held symbol.
  always_ff @(posedge clk_16M384) begin
    if (!rst_16M384) begin
      acc_d    <= {AW{1'b0}};
      acc_e    <= {AW{1'b0}};
      sym_d    <= {AW{1'b0}};
      sym_e    <= {AW{1'b0}};
      sym_push <= 1'b0;
      sym_last <= 1'b0;
      sym_bpsk <= 1'b0;
    end else begin
      if (dump1) begin
        acc_d    <= {AW{1'b0}};
        acc_e    <= {AW{1'b0}};
        sym_d    <= acc_d_next;
        sym_e    <= acc_e_next;
        sym_last <= last1;
        sym_bpsk <= bpsk1;
      end else begin
        acc_d <= acc_d_next;
        acc_e <= acc_e_next;
      end
      sym_push <= dump1 & vld1;
    end
  end

  // Stage 3: register the constellation decision together with its side-band bits.
  always_ff @(posedge clk_16M384) begin
    if (!rst_16M384) begin
      dec_push <= 1'b0;
      dec_bits <= 2'b00;
      dec_last <= 1'b0;
      dec_bpsk <= 1'b0;
    end else begin
      dec_push <= sym_push;
      dec_bits <= decide(sym_d, sym_e, sym_bpsk);
      dec_last <= sym_last;
      dec_bpsk <= sym_bpsk;
    end
  end

  assign pop = out_valid & m_tready;

  // Two-entry output buffer: a head register that drives the stream and a spare behind it.
  always_ff @(posedge clk_16M384) begin
    if (!rst_16M384) begin
      out_valid <= 1'b0;
      out_bits  <= 2'b00;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
      buf_valid <= 1'b0;
      buf_bits  <= 2'b00;
      buf_last  <= 1'b0;
      buf_user  <= 1'b0;
      ovf       <= 1'b0;
    end else if (pop) begin
      if (buf_valid) begin
        out_bits <= buf_bits;
        out_last <= buf_last;
        out_user <= buf_user;
        if (dec_push) begin
          buf_bits <= dec_bits;
          buf_last <= dec_last;
          buf_user <= dec_bpsk;
        end else begin
          buf_valid <= 1'b0;
        end
      end else if (dec_push) begin
        out_bits <= dec_bits;
        out_last <= dec_last;
        out_user <= dec_bpsk;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (dec_push) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_bits  <= dec_bits;
        out_last  <= dec_last;
        out_user  <= dec_bpsk;
      end else if (!buf_valid) begin
        buf_valid <= 1'b1;
        buf_bits  <= dec_bits;
        buf_last  <= dec_last;
        buf_user  <= dec_bpsk;
      end else begin
        ovf <= 1'b1;
      end
    end
  end

  assign m_tdata       = {{(OW-2){1'b0}}, out_bits};
  assign m_tvalid      = out_valid;
  assign m_tlast       = out_last;
  assign m_tuser       = out_user;
  assign overflow      = ovf;
  assign sym_clk_1M024 = cnt[3];

endmodule

// File: tb/tb_psk_demod.sv
// Self-checking bench for psk_demod: directed scenarios plus a randomized run,
// all checked against a sample-level behavioural model of the demodulator.
module tb_psk_demod;

  logic clk = 1'b0;
  always #30 clk = ~clk;

  logic               rst;
  logic signed [11:0] rx_i, rx_q, c_i, c_q;
  logic               vld, last, bpsk, tready;
  logic [3:0]         dump_cnt;
  logic [7:0]         tdata;
  logic               tvalid, tlast, tuser, ovf, symclk;

  int tests  = 0;
  int failed = 0;

  typedef struct { int due; logic [1:0] bits; logic lst; logic usr; } sym_t;
  typedef struct { logic [7:0] data; logic lst; logic usr; } out_t;

  sym_t   pend[$];
  out_t   q[$];
  out_t   exp_out[$];
  out_t   got[$];
  int     cnt_m  = 0;
  int     edge_n = 0;
  longint acc_d  = 0;
  longint acc_e  = 0;
  bit     ovf_m  = 1'b0;

  psk_demod #(.WIDTH(12), .BYTES(1)) dut (
    .clk_16M384(clk), .rst_16M384(rst),
    .rx_I(rx_i), .rx_Q(rx_q), .rx_vld(vld), .rx_last(last), .rx_is_bpsk(bpsk),
    .carrier_I(c_i), .carrier_Q(c_q), .DUMP_CNT(dump_cnt),
    .m_tdata(tdata), .m_tvalid(tvalid), .m_tready(tready), .m_tlast(tlast),
    .m_tuser(tuser), .overflow(ovf), .sym_clk_1M024(symclk)
  );

  function automatic logic [1:0] ref_decide(longint sd, longint se, bit bp);
    longint ad;
    longint ae;
    ad = (sd < 0) ? -sd : sd;
    ae = (se < 0) ? -se : se;
    if (bp) return (sd < 0) ? 2'b10 : 2'b00;
    if (ad >= ae) return (sd >= 0) ? 2'b00 : 2'b11;
    return (se > 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic signed [11:0] rnd_amp();
    int v;
    v = int'($urandom_range(3000)) - 1500;
    return 12'(v);
  endfunction

  // Observe a handshake, advance the model over the coming edge, then move to the next negedge.
  task automatic tick();
    out_t   o;
    sym_t   s;
    bit     pop, dump;
    longint d, e;
    if (rst) begin
      if (tvalid && tready) begin
        o.data = tdata; o.lst = tlast; o.usr = tuser;
        got.push_back(o);
      end
      pop = (q.size() > 0) && tready;
      if (pop) exp_out.push_back(q.pop_front());
      if (pend.size() > 0 && pend[0].due == edge_n) begin
        s = pend.pop_front();
        o.data = {6'd0, s.bits}; o.lst = s.lst; o.usr = s.usr;
        if (q.size() >= 2) ovf_m = 1'b1;
        else q.push_back(o);
      end
      dump = (cnt_m == int'(dump_cnt));
      if (vld) begin
        d = longint'(rx_i) * longint'(c_i) + longint'(rx_q) * longint'(c_q);
        e = longint'(rx_i) * longint'(c_q) - longint'(rx_q) * longint'(c_i);
      end else begin
        d = 0; e = 0;
      end
      acc_d += d;
      acc_e += e;
      if (dump) begin
        if (vld) begin
          s.due = edge_n + 3; s.bits = ref_decide(acc_d, acc_e, bpsk);
          s.lst = last; s.usr = bpsk;
          pend.push_back(s);
        end
        acc_d = 0; acc_e = 0;
      end
      cnt_m = (cnt_m + 1) % 16;
    end else begin
      pend.delete(); q.delete();
      acc_d = 0; acc_e = 0; ovf_m = 1'b0; cnt_m = 0;
    end
    edge_n++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    vld = 1'b0; last = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // Idle until the next sample is the first of a symbol (at most 16 cycles).
  task automatic align();
    vld = 1'b0; last = 1'b0;
    for (int k = 0; k < 16 && cnt_m != ((int'(dump_cnt) + 1) % 16); k++) tick();
  endtask

  task automatic send_symbol(input int i, input int qq, input int ci, input int cq,
                             input bit bp, input bit vld_dump, input bit last_dump);
    for (int k = 0; k < 16; k++) begin
      rx_i = 12'(i); rx_q = 12'(qq); c_i = 12'(ci); c_q = 12'(cq); bpsk = bp;
      vld  = (k == 15) ? vld_dump : 1'b1;
      last = (k == 15) ? last_dump : 1'b0;
      tick();
    end
    vld = 1'b0; last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; vld = 1'b0; last = 1'b0; bpsk = 1'b0; tready = 1'b1; dump_cnt = 4'd15;
    rx_i = 12'sd0; rx_q = 12'sd0; c_i = 12'sd0; c_q = 12'sd0;
    repeat (3) tick();
    tests++; if (tvalid !== 1'b0) begin failed++; $display("FAIL reset_tvalid: got %b exp 0", tvalid); end
    tests++; if (tdata !== 8'h00) begin failed++; $display("FAIL reset_tdata: got %h exp 00", tdata); end
    tests++; if (tlast !== 1'b0) begin failed++; $display("FAIL reset_tlast: got %b exp 0", tlast); end
    tests++; if (tuser !== 1'b0) begin failed++; $display("FAIL reset_tuser: got %b exp 0", tuser); end
    tests++; if (ovf !== 1'b0) begin failed++; $display("FAIL reset_overflow: got %b exp 0", ovf); end
    tests++; if (symclk !== 1'b0) begin failed++; $display("FAIL reset_symclk: got %b exp 0", symclk); end
    rst = 1'b1;
  endtask

  task automatic test_qpsk00();
    tready = 1'b1; align(); got.delete(); exp_out.delete();
    send_symbol(1000, 0, 1000, 0, 1'b0, 1'b1, 1'b0);
    tick();
    tests++; if (tvalid !== 1'b0) begin failed++; $display("FAIL q00_lat1: tvalid got %b exp 0", tvalid); end
    tick();
    tests++; if (tvalid !== 1'b0) begin failed++; $display("FAIL q00_lat2: tvalid got %b exp 0", tvalid); end
    tick();
    tests++; if (tvalid !== 1'b1) begin failed++; $display("FAIL q00_lat3: tvalid got %b exp 1", tvalid); end
    tests++; if (tdata !== 8'h00) begin failed++; $display("FAIL q00_data: got %h exp 00", tdata); end
    tests++; if (tuser !== 1'b0) begin failed++; $display("FAIL q00_user: got %b exp 0", tuser); end
    tests++; if (tvalid !== (q.size() > 0)) begin failed++; $display("FAIL q00_model_valid: got %b exp %b", tvalid, q.size() > 0); end
    idle(4);
  endtask

  task automatic test_qpsk_points();
    logic [7:0] exp4 [4];
    exp4 = '{8'h00, 8'h02, 8'h03, 8'h01};
    tready = 1'b1; align(); got.delete(); exp_out.delete();
    send_symbol( 700,  700, 700, 700, 1'b0, 1'b1, 1'b0);
    send_symbol( 700, -700, 700, 700, 1'b0, 1'b1, 1'b0);
    send_symbol(-700, -700, 700, 700, 1'b0, 1'b1, 1'b0);
    send_symbol(-700,  700, 700, 700, 1'b0, 1'b1, 1'b0);
    idle(6);
    tests++; if (got.size() != 4) begin failed++; $display("FAIL qpts_count: got %0d exp 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      tests++; if (got[k].data !== exp4[k]) begin failed++; $display("FAIL qpts_data[%0d]: got %h exp %h", k, got[k].data, exp4[k]); end
    end
  endtask

  task automatic test_bpsk();
    tready = 1'b1; align(); got.delete(); exp_out.delete();
    send_symbol(-1000, 0, 1000, 0, 1'b1, 1'b1, 1'b0);
    send_symbol( 1000, 0, 1000, 0, 1'b1, 1'b1, 1'b0);
    idle(6);
    tests++; if (got.size() != 2) begin failed++; $display("FAIL bpsk_count: got %0d exp 2", got.size()); end
    if (got.size() == 2) begin
      tests++; if (got[0].data !== 8'h02) begin failed++; $display("FAIL bpsk_neg_data: got %h exp 02", got[0].data); end
      tests++; if (got[0].usr !== 1'b1) begin failed++; $display("FAIL bpsk_neg_user: got %b exp 1", got[0].usr); end
      tests++; if (got[1].data !== 8'h00) begin failed++; $display("FAIL bpsk_pos_data: got %h exp 00", got[1].data); end
      tests++; if (got[1].usr !== 1'b1) begin failed++; $display("FAIL bpsk_pos_user: got %b exp 1", got[1].usr); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    tready = 1'b0; align(); got.delete(); exp_out.delete();
    send_symbol( 700,  700, 700, 700, 1'b0, 1'b1, 1'b0);
    send_symbol( 700, -700, 700, 700, 1'b0, 1'b1, 1'b0);
    tests++; if (tvalid !== 1'b1) begin failed++; $display("FAIL bp_valid: got %b exp 1", tvalid); end
    tests++; if (ovf !== 1'b0) begin failed++; $display("FAIL bp_no_ovf_yet: got %b exp 0", ovf); end
    held = tdata;
    tests++; if (held !== 8'h00) begin failed++; $display("FAIL bp_head: got %h exp 00", held); end
    send_symbol(-700, -700, 700, 700, 1'b0, 1'b1, 1'b0);
    tests++; if (tdata !== held) begin failed++; $display("FAIL bp_stable: got %h exp %h", tdata, held); end
    send_symbol(-700,  700, 700, 700, 1'b0, 1'b1, 1'b0);
    idle(4);
    tests++; if (ovf !== 1'b1) begin failed++; $display("FAIL bp_overflow: got %b exp 1", ovf); end
    tests++; if (tdata !== held) begin failed++; $display("FAIL bp_stable2: got %h exp %h", tdata, held); end
    tests++; if (ovf !== ovf_m) begin failed++; $display("FAIL bp_ovf_model: got %b exp %b", ovf, ovf_m); end
    tready = 1'b1;
    idle(8);
    tests++; if (got.size() != 2) begin failed++; $display("FAIL bp_count: got %0d exp 2", got.size()); end
    if (got.size() == 2) begin
      tests++; if (got[0].data !== 8'h00) begin failed++; $display("FAIL bp_first: got %h exp 00", got[0].data); end
      tests++; if (got[1].data !== 8'h02) begin failed++; $display("FAIL bp_second: got %h exp 02", got[1].data); end
    end
    tests++; if (ovf !== 1'b1) begin failed++; $display("FAIL bp_sticky: got %b exp 1", ovf); end
  endtask

  task automatic test_valid_last();
    tready = 1'b1; align(); got.delete(); exp_out.delete();
    send_symbol(1000, 0, 1000, 0, 1'b0, 1'b0, 1'b0);
    idle(6);
    tests++; if (got.size() != 0) begin failed++; $display("FAIL vld_drop: got %0d outputs exp 0", got.size()); end
    align();
    send_symbol(-1000, 0, 1000, 0, 1'b0, 1'b1, 1'b1);
    idle(6);
    tests++; if (got.size() != 1) begin failed++; $display("FAIL last_count: got %0d exp 1", got.size()); end
    if (got.size() == 1) begin
      tests++; if (got[0].lst !== 1'b1) begin failed++; $display("FAIL last_flag: got %b exp 1", got[0].lst); end
      tests++; if (got[0].data !== 8'h03) begin failed++; $display("FAIL last_data: got %h exp 03", got[0].data); end
    end
  endtask

  task automatic test_reset_mid();
    tready = 1'b0; align(); got.delete(); exp_out.delete();
    send_symbol(-1000, 0, 1000, 0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      rx_i = 12'sd900; rx_q = 12'sd0; vld = 1'b1; tick();
    end
    tests++; if (tvalid !== 1'b1) begin failed++; $display("FAIL rm_buffered: got %b exp 1", tvalid); end
    rst = 1'b0; vld = 1'b0;
    tick();
    tests++; if (tvalid !== 1'b0) begin failed++; $display("FAIL rm_tvalid: got %b exp 0", tvalid); end
    tests++; if (tdata !== 8'h00) begin failed++; $display("FAIL rm_tdata: got %h exp 00", tdata); end
    tests++; if (tlast !== 1'b0) begin failed++; $display("FAIL rm_tlast: got %b exp 0", tlast); end
    tests++; if (tuser !== 1'b0) begin failed++; $display("FAIL rm_tuser: got %b exp 0", tuser); end
    tests++; if (symclk !== 1'b0) begin failed++; $display("FAIL rm_symclk: got %b exp 0", symclk); end
    rst = 1'b1; tready = 1'b1;
    idle(7);
    tests++; if (symclk !== 1'b0) begin failed++; $display("FAIL rm_cnt7: symclk got %b exp 0", symclk); end
    idle(1);
    tests++; if (symclk !== 1'b1) begin failed++; $display("FAIL rm_cnt8: symclk got %b exp 1", symclk); end
    idle(40);
    tests++; if (got.size() != 0) begin failed++; $display("FAIL rm_stale: got %0d outputs exp 0", got.size()); end
  endtask

  task automatic test_random();
    int pct;
    got.delete(); exp_out.delete();
    for (int k = 0; k < 4000; k++) begin
      tests++; if (tvalid !== (q.size() > 0)) begin failed++; $display("FAIL rnd_valid@%0d: got %b exp %b", k, tvalid, q.size() > 0); end
      tests++; if (ovf !== ovf_m) begin failed++; $display("FAIL rnd_ovf@%0d: got %b exp %b", k, ovf, ovf_m); end
      tests++; if (symclk !== 1'(cnt_m >> 3)) begin failed++; $display("FAIL rnd_symclk@%0d: got %b exp %b", k, symclk, 1'(cnt_m >> 3)); end
      if (q.size() > 0) begin
        tests++; if (tdata !== q[0].data || tlast !== q[0].lst || tuser !== q[0].usr)
          begin failed++; $display("FAIL rnd_head@%0d: got %h/%b/%b exp %h/%b/%b", k, tdata, tlast, tuser, q[0].data, q[0].lst, q[0].usr); end
      end
      pct    = ((k / 500) % 2 == 1) ? 20 : 90;
      tready = ($urandom_range(99) < pct);
      vld    = ($urandom_range(9) != 0);
      last   = ($urandom_range(9) == 0);
      bpsk   = ($urandom_range(9) < 3);
      rx_i = rnd_amp(); rx_q = rnd_amp(); c_i = rnd_amp(); c_q = rnd_amp();
      if ($urandom_range(99) == 0) dump_cnt = 4'($urandom_range(15));
      tick();
    end
    tests++; if (got.size() != exp_out.size()) begin failed++; $display("FAIL rnd_count: got %0d exp %0d", got.size(), exp_out.size()); end
    for (int k = 0; k < got.size() && k < exp_out.size(); k++) begin
      tests++; if (got[k] !== exp_out[k]) begin failed++; $display("FAIL rnd_stream[%0d]: got %h/%b/%b exp %h/%b/%b", k, got[k].data, got[k].lst, got[k].usr, exp_out[k].data, exp_out[k].lst, exp_out[k].usr); end
    end
  endtask

  initial begin
    rst = 1'b0; vld = 1'b0; last = 1'b0; bpsk = 1'b0; tready = 1'b1; dump_cnt = 4'd15;
    rx_i = 12'sd0; rx_q = 12'sd0; c_i = 12'sd0; c_q = 12'sd0;
    @(negedge clk);
    test_reset();
    test_qpsk00();
    test_qpsk_points();
    test_bpsk();
    test_backpressure();
    test_valid_last();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
